// File: rtl/pc_alu.sv
//------------------------------------------------------------------------------
// pc_alu -- next-program-counter unit for the 16-bit core.
//
// On every enabled rising clock edge one of three next-PC values is registered:
//   - jalEN  = 1 : absolute register target RTarget (jump-and-link); the return
//                  address pc + 1 is registered on Rlink.
//   - jumpEN = 1 : PC-relative target pc + immediate (no implicit +1).
//   - otherwise  : sequential pc + 1.
// jalEN has priority over jumpEN. Rlink is 0 for every non-JAL update. All sums
// are WIDTH-bit and wrap silently. With en low every registered output holds.
// The outputs come straight from flops, so there is no combinational path from
// any input to any output.
//
// Parameters:
//   WIDTH     datapath width of pc, immediate, RTarget, pcOut and Rlink
//   RESET_PC  value forced onto pcOut while rst_n is low
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   update enable (low = stall, hold outputs)
//   pc         in   current program counter
//   immediate  in   two's complement PC-relative offset
//   jumpEN     in   select pc + immediate
//   RTarget    in   absolute JAL target
//   jalEN      in   select RTarget and produce a link value
//   pcOut      out  registered next PC
//   Rlink      out  registered return address (pc + 1) for JAL, else 0
//   jmpOvf     out  registered signed-overflow flag of the relative jump add;
//                   only present when PC_ALU_OVERFLOW_FLAG_EN is defined
//
// Build option:
//   PC_ALU_OVERFLOW_FLAG_EN  adds the jmpOvf output and its logic.
//------------------------------------------------------------------------------
module pc_alu #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] immediate,
   input  logic             jumpEN,
   input  logic [WIDTH-1:0] RTarget,
   input  logic             jalEN,
   output logic [WIDTH-1:0] pcOut,
   output logic [WIDTH-1:0] Rlink
`ifdef PC_ALU_OVERFLOW_FLAG_EN
   ,
   output logic             jmpOvf
`endif
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] pc_out_q;
   logic [WIDTH-1:0] pc_out_d;
   logic [WIDTH-1:0] rlink_q;
   logic [WIDTH-1:0] rlink_d;

   // Both sums are kept at WIDTH bits so the carry-out is dropped (silent wrap).
   logic [WIDTH-1:0] pc_inc_s;
   logic [WIDTH-1:0] jump_sum_s;

   assign pc_inc_s   = pc + ONE;
   assign jump_sum_s = pc + immediate;

   // Next-state selection: JAL beats relative jump beats sequential; stall holds.
   always_comb begin
      pc_out_d = pc_out_q;
      rlink_d  = rlink_q;
      if (en) begin
         if (jalEN) begin
            pc_out_d = RTarget;
            rlink_d  = pc_inc_s;
         end else if (jumpEN) begin
            pc_out_d = jump_sum_s;
            rlink_d  = ZERO;
         end else begin
            pc_out_d = pc_inc_s;
            rlink_d  = ZERO;
         end
      end else begin
         pc_out_d = pc_out_q;
         rlink_d  = rlink_q;
      end
   end

   // Output registers with asynchronous reset to the boot PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_out_q <= RESET_PC;
         rlink_q  <= ZERO;
      end else begin
         pc_out_q <= pc_out_d;
         rlink_q  <= rlink_d;
      end
   end

   assign pcOut = pc_out_q;
   assign Rlink = rlink_q;

`ifdef PC_ALU_OVERFLOW_FLAG_EN
   logic jmp_ovf_q;
   logic jmp_ovf_d;
   logic add_ovf_s;

   // Signed overflow: operands agree in sign but the sum's sign differs.
   assign add_ovf_s = (pc[WIDTH-1] == immediate[WIDTH-1]) &&
                      (jump_sum_s[WIDTH-1] != pc[WIDTH-1]);

   // Flag is raised only when the relative-jump path is the one being taken.
   always_comb begin
      jmp_ovf_d = jmp_ovf_q;
      if (en) begin
         if (!jalEN && jumpEN) begin
            jmp_ovf_d = add_ovf_s;
         end else begin
            jmp_ovf_d = 1'b0;
         end
      end else begin
         jmp_ovf_d = jmp_ovf_q;
      end
   end

   // Overflow flag register, same timing and reset behaviour as pcOut.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jmp_ovf_q <= 1'b0;
      end else begin
         jmp_ovf_q <= jmp_ovf_d;
      end
   end

   assign jmpOvf = jmp_ovf_q;
`endif

endmodule

// File: tb/tb_pc_alu.sv
//------------------------------------------------------------------------------
// tb_pc_alu -- self-checking bench for pc_alu.
// Directed cases for reset, each selection path, wrap-around and stall, then
// randomized traffic compared against a behavioural next-PC model.
//------------------------------------------------------------------------------
module tb_pc_alu;

   localparam int          W        = 16;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [W-1:0]  pc;
   logic [W-1:0]  immediate;
   logic          jumpEN;
   logic [W-1:0]  RTarget;
   logic          jalEN;
   logic [W-1:0]  pcOut;
   logic [W-1:0]  Rlink;
`ifdef PC_ALU_OVERFLOW_FLAG_EN
   logic          jmpOvf;
`endif

   int n_checks;
   int n_fail;

   // model state: what the outputs must hold
   logic [W-1:0] exp_pc;
   logic [W-1:0] exp_link;
   logic         exp_ovf;

   pc_alu #(.WIDTH(W), .RESET_PC(RESET_PC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .pc        (pc),
      .immediate (immediate),
      .jumpEN    (jumpEN),
      .RTarget   (RTarget),
      .jalEN     (jalEN),
      .pcOut     (pcOut),
      .Rlink     (Rlink)
`ifdef PC_ALU_OVERFLOW_FLAG_EN
      ,
      .jmpOvf    (jmpOvf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".pcOut"}, {16'h0000, pcOut}, {16'h0000, exp_pc});
      check_val({tag, ".Rlink"}, {16'h0000, Rlink}, {16'h0000, exp_link});
`ifdef PC_ALU_OVERFLOW_FLAG_EN
      check_val({tag, ".jmpOvf"}, {31'h0, jmpOvf}, {31'h0, exp_ovf});
`endif
   endtask

   // Behavioural model of one enabled edge, using integer arithmetic mod 2^16.
   task automatic model_edge(input logic e, input logic jal, input logic jmp,
                             input logic [W-1:0] p, input logic [W-1:0] imm,
                             input logic [W-1:0] tgt);
      int unsigned sp;
      int unsigned si;
      int          sum_signed;
      if (e) begin
         sp = p;
         si = imm;
         if (jal) begin
            exp_pc   = tgt;
            exp_link = 16'((sp + 1) % 65536);
            exp_ovf  = 1'b0;
         end else if (jmp) begin
            exp_pc   = 16'((sp + si) % 65536);
            exp_link = 16'h0000;
            sum_signed = int'($signed(p)) + int'($signed(imm));
            exp_ovf  = (sum_signed > 32767 || sum_signed < -32768);
         end else begin
            exp_pc   = 16'((sp + 1) % 65536);
            exp_link = 16'h0000;
            exp_ovf  = 1'b0;
         end
      end
   endtask

   // Drive one cycle's inputs, cross the rising edge, then check away from it.
   task automatic apply(input string tag, input logic e, input logic jal, input logic jmp,
                        input logic [W-1:0] p, input logic [W-1:0] imm,
                        input logic [W-1:0] tgt);
      en        = e;
      jalEN     = jal;
      jumpEN    = jmp;
      pc        = p;
      immediate = imm;
      RTarget   = tgt;
      @(posedge clk);
      model_edge(e, jal, jmp, p, imm, tgt);
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [W-1:0] pick_val();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0: v = 16'hffff;
         1: v = 16'h7fff;
         2: v = 16'h8000;
         3: v = 16'h0000;
         default: v = 16'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      en        = 1'b0;
      pc        = 16'h0000;
      immediate = 16'h0000;
      jumpEN    = 1'b0;
      RTarget   = 16'h0000;
      jalEN     = 1'b0;
      exp_pc    = RESET_PC;
      exp_link  = 16'h0000;
      exp_ovf   = 1'b0;

      // reset value visible before the first clock edge
      #3;
      check_outputs("reset_async");
      #4;
      check_outputs("reset_held");
      rst_n = 1'b1;

      apply("seq",        1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      check_val("seq_lit", {16'h0, pcOut}, 32'h0000_0001);
      apply("rel_jump",   1'b1, 1'b0, 1'b1, 16'h0001, 16'h0009, 16'h0000);
      check_val("rel_lit", {16'h0, pcOut}, 32'h0000_000a);
      apply("jal",        1'b1, 1'b1, 1'b0, 16'h000a, 16'h0000, 16'h1000);
      check_val("jal_link_lit", {16'h0, Rlink}, 32'h0000_000b);
      apply("jal_prio",   1'b1, 1'b1, 1'b1, 16'h000a, 16'h0005, 16'h1000);
      check_val("jal_prio_lit", {16'h0, pcOut}, 32'h0000_1000);
      apply("neg_off",    1'b1, 1'b0, 1'b1, 16'hfff1, 16'hffff, 16'h0000);
      check_val("neg_off_lit", {16'h0, pcOut}, 32'h0000_fff0);
      apply("neg_off2",   1'b1, 1'b0, 1'b1, 16'hffff, 16'hfffe, 16'h0000);
      check_val("neg_off2_lit", {16'h0, pcOut}, 32'h0000_fffd);
      apply("seq_wrap",   1'b1, 1'b0, 1'b0, 16'hffff, 16'h0000, 16'h0000);
      check_val("seq_wrap_lit", {16'h0, pcOut}, 32'h0000_0000);
      apply("link_wrap",  1'b1, 1'b1, 1'b0, 16'hffff, 16'h0000, 16'h2222);
      check_val("link_wrap_lit", {16'h0, Rlink}, 32'h0000_0000);
      apply("jal_set",    1'b1, 1'b1, 1'b0, 16'h1233, 16'h0000, 16'h4444);

      // stall: inputs change, outputs must not
      for (int i = 0; i < 3; i++) begin
         apply($sformatf("stall%0d", i), 1'b0, 1'(i % 2), 1'b1,
               16'(16'h0100 + i), 16'h0040, 16'h0bad);
         check_val($sformatf("stall_lit%0d", i), {16'h0, pcOut}, 32'h0000_4444);
      end

      // asynchronous reset pulse between edges
      #2;
      rst_n    = 1'b0;
      exp_pc   = RESET_PC;
      exp_link = 16'h0000;
      exp_ovf  = 1'b0;
      #1;
      check_outputs("reset_pulse");
      #1;
      rst_n = 1'b1;

`ifdef PC_ALU_OVERFLOW_FLAG_EN
      apply("ovf_pos",    1'b1, 1'b0, 1'b1, 16'h7fff, 16'h0001, 16'h0000);
      check_val("ovf_lit", {31'h0, jmpOvf}, 32'h0000_0001);
      apply("ovf_neg",    1'b1, 1'b0, 1'b1, 16'h8000, 16'hffff, 16'h0000);
      apply("ovf_jal",    1'b1, 1'b1, 1'b1, 16'h7fff, 16'h0001, 16'h0010);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         apply($sformatf("rand%0d", i),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)),
               pick_val(), pick_val(), pick_val());
         if ($urandom_range(0, 49) == 0) begin
            #2;
            rst_n    = 1'b0;
            exp_pc   = RESET_PC;
            exp_link = 16'h0000;
            exp_ovf  = 1'b0;
            #1;
            check_outputs($sformatf("rand_rst%0d", i));
            rst_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_alu.md
Name: pc_alu

Overview:
- Next-program-counter unit for the 16-bit core, sitting between the fetch stage and the PC register consumers.
- Each enabled cycle it selects one of three next-PC values and registers it:
  - sequential increment,
  - PC-relative jump (branch/jump immediate),
  - register-target jump-and-link (JAL).
- For JAL it also registers the return address for write-back to the link register.

Parameters:
- WIDTH, 16, datapath width of PC, immediate, target and link values.
- RESET_PC, 0, value loaded into pcOut on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  update enable; low = hold all registered outputs (stall)
- pc  input  WIDTH  current program counter
- immediate  input  WIDTH  PC-relative offset, two's complement
- jumpEN  input  1  select pc + immediate
- RTarget  input  WIDTH  absolute target for JAL
- jalEN  input  1  select RTarget and produce link value
- pcOut  output  WIDTH  registered next PC
- Rlink  output  WIDTH  registered return address (pc + 1) for JAL, else 0

Behaviour:
- Reset:
  - rst_n low asynchronously forces pcOut = RESET_PC and Rlink = 0.
  - Values are held while rst_n is low.
  - Release is sampled on the next rising clk edge.
  - Reset asserted mid-operation discards any pending update immediately.
- Latency: one cycle. Inputs sampled on the rising edge with en = 1; results visible after that edge. No combinational input-to-output path.
- en = 0: pcOut and Rlink hold their previous values. Inputs are ignored.
- Next-PC selection on an enabled edge, in priority order:
  - jalEN = 1: pcOut <= RTarget; Rlink <= pc + 1. jumpEN is ignored when both are set.
  - jalEN = 0, jumpEN = 1: pcOut <= pc + immediate (no implicit +1); Rlink <= 0.
  - both 0: pcOut <= pc + 1; Rlink <= 0.
- Arithmetic:
  - All additions are WIDTH-bit modulo 2^WIDTH.
  - Carry-out is discarded, so wrap-around is silent: ffff + 1 = 0000, fff1 + ffff = fff0.
  - Immediate is effectively signed: all-ones = -1.
- Rlink at pc = ffff with JAL wraps to 0000.
- Outputs depend only on the sampled inputs for that edge, not on prior pcOut. The caller feeds pcOut back to pc externally.

Optional Feature:
- Macro PC_ALU_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output jmpOvf (1 bit, registered, same timing and enable as pcOut, reset 0).
  - On an enabled edge, jmpOvf <= 1 only when the jump path is selected (jalEN = 0, jumpEN = 1) and pc + immediate overflows as a signed add: both operands share an MSB and the sum MSB differs. Otherwise jmpOvf <= 0.
  - The pcOut value is unaffected (still wraps).
- Undefined: port absent; no logic generated.

Test Plan:
- Reset: assert rst_n = 0 with clock running, RESET_PC = 0 -> pcOut = 0000, Rlink = 0000 immediately, without waiting for a clock edge.
- Sequential: pc = 0000, jumpEN = 0, jalEN = 0, en = 1 -> after one edge pcOut = 0001, Rlink = 0000.
- Relative jump: pc = 0001, immediate = 0009, jumpEN = 1 -> pcOut = 000a, Rlink = 0000.
- JAL priority and link:
  - pc = 000a, jalEN = 1, jumpEN = 0, RTarget = 1000 -> pcOut = 1000, Rlink = 000b.
  - Repeat with jumpEN = 1 -> same result.
- Negative offset / wrap:
  - pc = fff1, immediate = ffff, jumpEN = 1 -> pcOut = fff0.
  - pc = ffff, immediate = fffe -> pcOut = fffd.
  - pc = ffff, no jump -> pcOut = 0000.
- Stall and async reset:
  - en = 0 with changing inputs -> outputs unchanged across 3 edges.
  - Pulse rst_n low between edges -> outputs clear at once.
  - With PC_ALU_OVERFLOW_FLAG_EN: pc = 7fff, immediate = 0001, jump -> pcOut = 8000, jmpOvf = 1.
